// File: rtl/bip_pkg.sv
// Shared encodings for the BIP sequencer: opcodes, accumulator-source codes,
// FSM state encoding and the datapath control word.
package bip_pkg;

  localparam logic [2:0] OP_HALT = 3'd0;
  localparam logic [2:0] OP_STO  = 3'd1;
  localparam logic [2:0] OP_LD   = 3'd2;
  localparam logic [2:0] OP_LDI  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_SUBI = 3'd7;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_EXEC     = 3'd2;
  localparam logic [2:0] ST_MEM_WAIT = 3'd3;
  localparam logic [2:0] ST_WB       = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;

  typedef struct packed {
    logic       wr_pc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/bip_op_decode.sv
// Combinational decode of the latched opcode into the EXEC-phase and
// write-back-phase control words plus instruction class flags.
module bip_op_decode
  import bip_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output ctrl_t               o_exec_ctrl,
  output ctrl_t               o_wb_ctrl,
  output logic                o_is_mem_read,
  output logic                o_is_halt,
  output logic                o_is_illegal
);

  logic [2:0] w_op;

  assign w_op         = i_opcode[2:0];
  assign o_is_illegal = (i_opcode >> 3) != '0;

  always_comb begin
    o_exec_ctrl   = CTRL_NONE;
    o_wb_ctrl     = CTRL_NONE;
    o_is_mem_read = 1'b0;
    o_is_halt     = 1'b0;
    if (!o_is_illegal) begin
      case (w_op)
        OP_HALT: o_is_halt = 1'b1;
        OP_STO: begin
          o_exec_ctrl.wr_ram = 1'b1;
          o_exec_ctrl.wr_pc  = 1'b1;
        end
        OP_LD: begin
          o_exec_ctrl.rd_ram = 1'b1;
          o_is_mem_read      = 1'b1;
          o_wb_ctrl.sel_a    = SELA_RAM;
          o_wb_ctrl.wr_acc   = 1'b1;
          o_wb_ctrl.wr_pc    = 1'b1;
        end
        OP_LDI: begin
          o_exec_ctrl.sel_a  = SELA_IMM;
          o_exec_ctrl.wr_acc = 1'b1;
          o_exec_ctrl.wr_pc  = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          o_exec_ctrl.rd_ram = 1'b1;
          o_is_mem_read      = 1'b1;
          o_wb_ctrl.sel_a    = SELA_ALU;
          o_wb_ctrl.sel_b    = 1'b0;
          o_wb_ctrl.op       = (w_op == OP_ADD);
          o_wb_ctrl.wr_acc   = 1'b1;
          o_wb_ctrl.wr_pc    = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          o_exec_ctrl.sel_a  = SELA_ALU;
          o_exec_ctrl.sel_b  = 1'b1;
          o_exec_ctrl.op     = (w_op == OP_ADDI);
          o_exec_ctrl.wr_acc = 1'b1;
          o_exec_ctrl.wr_pc  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bip_sequencer.sv
// Multi-cycle fetch/execute sequencer for the BIP CPU with RAM read latency,
// illegal-opcode trap, sticky halt and a saturating retired-instruction counter.
module bip_sequencer
  import bip_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int RAM_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic                i_instr_valid,
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_wr_pc,
  output logic [1:0]          o_sel_a,
  output logic                o_sel_b,
  output logic                o_wr_acc,
  output logic                o_op,
  output logic                o_wr_ram,
  output logic                o_rd_ram,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_illegal,
  output logic [CNT_W-1:0]    o_retired
);

  // Wait counter value on the last MEM_WAIT cycle (MEM_WAIT lasts RAM_LAT-1 cycles).
  localparam logic [2:0] WAIT_LAST = 3'((RAM_LAT > 1) ? RAM_LAT - 2 : 0);

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [OPCODE_W-1:0] r_opcode;
  logic [2:0]          r_wait;
  logic                r_illegal;
  logic [CNT_W-1:0]    r_retired;

  ctrl_t w_exec_ctrl;
  ctrl_t w_wb_ctrl;
  ctrl_t w_ctrl;
  logic  w_is_mem_read;
  logic  w_is_halt;
  logic  w_is_illegal;

  bip_op_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_op_decode (
    .i_opcode      (r_opcode),
    .o_exec_ctrl   (w_exec_ctrl),
    .o_wb_ctrl     (w_wb_ctrl),
    .o_is_mem_read (w_is_mem_read),
    .o_is_halt     (w_is_halt),
    .o_is_illegal  (w_is_illegal)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_run) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (!i_run) begin
          w_state_nxt = ST_IDLE;
        end else if (i_instr_valid) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_is_halt || w_is_illegal) begin
          w_state_nxt = ST_HALT;
        end else if (w_is_mem_read) begin
          w_state_nxt = (RAM_LAT == 1) ? ST_WB : ST_MEM_WAIT;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_MEM_WAIT: if (r_wait == WAIT_LAST) w_state_nxt = ST_WB;
      ST_WB:       w_state_nxt = ST_FETCH;
      ST_HALT:     w_state_nxt = ST_HALT;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_opcode  <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FETCH && i_run && i_instr_valid) begin
        r_opcode <= i_opcode;
      end
      if (r_state == ST_EXEC) begin
        r_wait <= '0;
      end else if (r_state == ST_MEM_WAIT) begin
        r_wait <= r_wait + 3'd1;
      end
      if (r_state == ST_EXEC && w_is_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_ctrl.wr_pc && (r_retired != '1)) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Strobes come only from registered state and opcode, never from i_opcode.
  always_comb begin
    w_ctrl = CTRL_NONE;
    case (r_state)
      ST_EXEC:     w_ctrl = w_exec_ctrl;
      ST_MEM_WAIT: w_ctrl.rd_ram = 1'b1;
      ST_WB:       w_ctrl = w_wb_ctrl;
      default:     w_ctrl = CTRL_NONE;
    endcase
  end

  assign o_wr_pc   = w_ctrl.wr_pc;
  assign o_sel_a   = w_ctrl.sel_a;
  assign o_sel_b   = w_ctrl.sel_b;
  assign o_wr_acc  = w_ctrl.wr_acc;
  assign o_op      = w_ctrl.op;
  assign o_wr_ram  = w_ctrl.wr_ram;
  assign o_rd_ram  = w_ctrl.rd_ram;
  assign o_busy    = (r_state == ST_FETCH) || (r_state == ST_EXEC) ||
                     (r_state == ST_MEM_WAIT) || (r_state == ST_WB);
  assign o_halted  = (r_state == ST_HALT);
  assign o_illegal = r_illegal;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_bip_sequencer.sv
// Self-checking bench for bip_sequencer: directed and random instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_bip_sequencer;

  localparam int OPCODE_W = 5;
  localparam int RAM_LAT  = 3;

  typedef struct packed {
    logic       wr_pc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
    logic       busy;
    logic       halted;
    logic       illegal;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                i_run;
  logic                i_instr_valid;
  logic [OPCODE_W-1:0] i_opcode;
  logic                o_wr_pc, o_sel_b, o_wr_acc, o_op, o_wr_ram, o_rd_ram;
  logic                o_busy, o_halted, o_illegal;
  logic [1:0]          o_sel_a;
  logic [15:0]         o_retired;

  logic                s_run, s_valid;
  logic [OPCODE_W-1:0] s_opcode;
  logic                s_wr_pc, s_sel_b, s_wr_acc, s_op, s_wr_ram, s_rd_ram;
  logic                s_busy, s_halted, s_illegal;
  logic [1:0]          s_sel_a;
  logic [1:0]          s_retired;

  exp_t obs_vec;
  assign obs_vec = {o_wr_pc, o_sel_a, o_sel_b, o_wr_acc, o_op, o_wr_ram, o_rd_ram,
                    o_busy, o_halted, o_illegal};

  bip_sequencer #(
    .OPCODE_W (OPCODE_W),
    .RAM_LAT  (RAM_LAT),
    .CNT_W    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (i_run),
    .i_instr_valid (i_instr_valid),
    .i_opcode      (i_opcode),
    .o_wr_pc       (o_wr_pc),
    .o_sel_a       (o_sel_a),
    .o_sel_b       (o_sel_b),
    .o_wr_acc      (o_wr_acc),
    .o_op          (o_op),
    .o_wr_ram      (o_wr_ram),
    .o_rd_ram      (o_rd_ram),
    .o_busy        (o_busy),
    .o_halted      (o_halted),
    .o_illegal     (o_illegal),
    .o_retired     (o_retired)
  );

  bip_sequencer #(
    .OPCODE_W (OPCODE_W),
    .RAM_LAT  (1),
    .CNT_W    (2)
  ) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (s_run),
    .i_instr_valid (s_valid),
    .i_opcode      (s_opcode),
    .o_wr_pc       (s_wr_pc),
    .o_sel_a       (s_sel_a),
    .o_sel_b       (s_sel_b),
    .o_wr_acc      (s_wr_acc),
    .o_op          (s_op),
    .o_wr_ram      (s_wr_ram),
    .o_rd_ram      (s_rd_ram),
    .o_busy        (s_busy),
    .o_halted      (s_halted),
    .o_illegal     (s_illegal),
    .o_retired     (s_retired)
  );

  int   checks = 0;
  int   errors = 0;
  int   ret_m = 0;
  logic prev_wr_pc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t fetch_v();
    exp_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t memw_v();
    exp_t e = '0;
    e.busy   = 1'b1;
    e.rd_ram = 1'b1;
    return e;
  endfunction

  function automatic exp_t halt_v(input logic ill);
    exp_t e = '0;
    e.halted  = 1'b1;
    e.illegal = ill;
    return e;
  endfunction

  function automatic logic is_mem(input int op);
    return (op == 2) || (op == 4) || (op == 6);
  endfunction

  // Strobes expected in the cycle after the opcode is fetched.
  function automatic exp_t exp_exec(input int op);
    exp_t e = '0;
    e.busy = 1'b1;
    case (op)
      1: begin e.wr_ram = 1'b1; e.wr_pc = 1'b1; end
      2, 4, 6: e.rd_ram = 1'b1;
      3: begin e.sel_a = 2'b01; e.wr_acc = 1'b1; e.wr_pc = 1'b1; end
      5, 7: begin
        e.sel_a = 2'b10; e.sel_b = 1'b1; e.op = (op == 5);
        e.wr_acc = 1'b1; e.wr_pc = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t exp_wb(input int op);
    exp_t e = '0;
    e.busy   = 1'b1;
    e.wr_acc = 1'b1;
    e.wr_pc  = 1'b1;
    if (op != 2) begin
      e.sel_a = 2'b10;
      e.op    = (op == 4);
    end
    return e;
  endfunction

  task automatic tick(input string tag, input exp_t expv);
    @(posedge clk);
    #1;
    if (prev_wr_pc && ret_m < 65535) ret_m++;
    chk(tag, 32'(obs_vec), 32'(expv));
    chk({tag, "_retired"}, 32'(o_retired), ret_m);
    prev_wr_pc = expv.wr_pc;
  endtask

  // Entry: the next edge moves the DUT into FETCH (after IDLE with run, or a final strobe).
  task automatic issue(input int op, input int gaps, input logic drop);
    i_run = 1'b1;
    i_instr_valid = 1'b0;
    i_opcode = OPCODE_W'($urandom);
    tick("fetch", fetch_v());
    for (int g = 0; g < gaps; g++) tick("fetch_gap", fetch_v());
    i_instr_valid = 1'b1;
    i_opcode = OPCODE_W'(op);
    tick("exec", exp_exec(op));
    i_instr_valid = 1'($urandom);
    i_opcode = OPCODE_W'($urandom);
    if (drop) i_run = 1'b0;
    if (op == 0 || op >= 8) begin
      for (int h = 0; h < 3; h++) begin
        i_run = 1'($urandom);
        i_instr_valid = 1'b1;
        i_opcode = OPCODE_W'($urandom);
        tick("halt", halt_v(op >= 8));
      end
      return;
    end
    if (is_mem(op)) begin
      for (int w = 0; w < RAM_LAT - 1; w++) tick("mem_wait", memw_v());
      tick("wb", exp_wb(op));
    end
    if (drop) begin
      tick("drop_fetch", fetch_v());
      tick("drop_idle", '0);
    end
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    i_run = 1'b0;
    i_instr_valid = 1'b0;
    #1;
    ret_m = 0;
    prev_wr_pc = 1'b0;
    chk("async_rst_outputs", 32'(obs_vec), 32'd0);
    chk("async_rst_retired", 32'(o_retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle_after_rst", '0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_run = 1'b0;
    i_instr_valid = 1'b0;
    i_opcode = '0;
    s_run = 1'b0;
    s_valid = 1'b0;
    s_opcode = '0;
    #1;
    chk("reset_outputs", 32'(obs_vec), 32'd0);
    chk("reset_retired", 32'(o_retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle", '0);

    issue(3, 0, 1'b0);
    issue(4, 0, 1'b0);
    issue(2, 4, 1'b1);
    issue(6, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      issue(int'($urandom_range(1, 7)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 4) == 0));
    end

    issue(1, 0, 1'b0);
    issue(7, 0, 1'b0);
    issue(0, 0, 1'b0);
    mid_reset();

    issue(9, 0, 1'b0);
    mid_reset();

    // Narrow counter, single-cycle RAM: five back-to-back LDI then one LD.
    s_run = 1'b1;
    s_valid = 1'b1;
    s_opcode = OPCODE_W'(3);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      chk("sat_wr_pc", 32'(s_wr_pc), 32'((c % 2) == 0));
      chk("sat_retired", 32'(s_retired), 32'(((c - 1) / 2 > 3) ? 3 : (c - 1) / 2));
    end
    s_opcode = OPCODE_W'(2);
    @(posedge clk);
    #1;
    s_run = 1'b0;
    s_valid = 1'b0;
    chk("lat1_exec", 32'({s_rd_ram, s_wr_pc, s_wr_acc}), 32'(3'b100));
    @(posedge clk);
    #1;
    chk("lat1_wb", 32'({s_rd_ram, s_wr_pc, s_wr_acc, s_sel_a}), 32'(5'b01100));
    chk("lat1_retired", 32'(s_retired), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_sequencer.md
Name: bip_sequencer

Overview:
- Multi-cycle control unit for the BIP CPU.
- Replaces the purely combinational opcode decoder with a registered sequencer that adds:
  - a fetch/execute state machine;
  - a configurable data-RAM read latency;
  - illegal-opcode trapping;
  - a sticky halt;
  - a retired-instruction counter.
- Sits between program memory (opcode source) and the datapath (PC, accumulator, ALU, data RAM).

Parameters:
- OPCODE_W, 5: opcode width; opcodes 0..7 are defined, all others are illegal.
- RAM_LAT, 1: cycles from the first o_rd_ram cycle to valid RAM data; legal range 1..7.
- CNT_W, 16: width of o_retired.

Ports:
- clk, input, 1: single system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- i_run, input, 1: level enable; the sequencer fetches while high.
- i_instr_valid, input, 1: program-memory opcode valid this cycle.
- i_opcode, input, OPCODE_W: instruction opcode.
- o_wr_pc, output, 1: PC increment strobe.
- o_sel_a, output, 2: accumulator source; 00 = RAM, 01 = immediate, 10 = ALU.
- o_sel_b, output, 1: ALU operand B; 0 = RAM, 1 = immediate.
- o_wr_acc, output, 1: accumulator write strobe.
- o_op, output, 1: ALU operation; 1 = add, 0 = subtract.
- o_wr_ram, output, 1: data-RAM write strobe.
- o_rd_ram, output, 1: data-RAM read enable.
- o_busy, output, 1: high in FETCH, EXEC, MEM_WAIT and WB.
- o_halted, output, 1: sticky; set by HALT or an illegal opcode.
- o_illegal, output, 1: sticky; set when an illegal opcode is executed.
- o_retired, output, CNT_W: count of cycles with o_wr_pc = 1; saturating.

Behaviour:
- Reset (asynchronous, no clock needed):
  - state = IDLE, opcode register = 0;
  - all strobes, o_sel_a, o_sel_b, o_op = 0;
  - o_busy = o_halted = o_illegal = 0, o_retired = 0.
  - Reset mid-instruction aborts the instruction immediately; no partial strobe follows.
- Strobe generation:
  - All strobes are decoded from the state register and the latched opcode register only.
  - i_opcode never drives outputs combinationally.
  - Don't-care fields are driven 0.
- IDLE: i_run = 1 -> FETCH on the next edge.
- FETCH:
  - i_run = 0 -> IDLE.
  - Otherwise, if i_instr_valid = 1: latch i_opcode, then -> EXEC.
  - Otherwise stay in FETCH with all strobes 0.
- EXEC, per latched opcode:
  - 0 HALT: no strobes; -> HALT.
  - 1 STO: o_wr_ram = 1, o_wr_pc = 1; -> FETCH.
  - 2 LD: o_rd_ram = 1; -> MEM_WAIT, or -> WB if RAM_LAT = 1.
  - 3 LDI: o_sel_a = 01, o_wr_acc = 1, o_wr_pc = 1; -> FETCH.
  - 4 ADD / 6 SUB: o_rd_ram = 1; -> MEM_WAIT, or -> WB if RAM_LAT = 1.
  - 5 ADDI / 7 SUBI: o_sel_a = 10, o_sel_b = 1, o_op = 1 for ADDI / 0 for SUBI, o_wr_acc = 1, o_wr_pc = 1; -> FETCH.
  - Opcode >= 8: set o_illegal; -> HALT with no strobes.
- MEM_WAIT:
  - o_rd_ram held at 1.
  - A wait counter of width 3 bits runs for RAM_LAT-1 cycles, then -> WB.
- WB:
  - o_rd_ram = 0, o_wr_acc = 1, o_wr_pc = 1.
  - LD: o_sel_a = 00.
  - ADD / SUB: o_sel_a = 10, o_sel_b = 0, o_op = 1 / 0.
  - -> FETCH.
- HALT:
  - o_halted = 1; all strobes 0.
  - Exit is by reset only; i_run is ignored.
- Latency:
  - Immediate instructions and STO: 2 cycles (FETCH + EXEC).
  - Memory-read instructions: 2 + RAM_LAT cycles.
- i_run falling mid-instruction: the current instruction completes; the sequencer drops to IDLE at the next FETCH.
- o_retired:
  - Increments in every cycle with o_wr_pc = 1.
  - Holds at 2^CNT_W - 1; no wrap.
- o_wr_pc and o_wr_ram / o_wr_acc are never high for more than one cycle per instruction.

Decomposition:
- Shared package bip_pkg holds:
  - opcode localparams (OP_HALT .. OP_SUBI);
  - o_sel_a codes (SELA_RAM, SELA_IMM, SELA_ALU);
  - state encoding (IDLE, FETCH, EXEC, MEM_WAIT, WB, HALT).
- One combinational sub-module, bip_op_decode:
  - input: latched opcode;
  - outputs: control word and an is_mem_read / is_illegal flag.
- The sequencer FSM, wait counter and retire counter stay in bip_sequencer.

Test Plan:
- Reset, then i_run = 1 with LDI (3) valid -> o_sel_a = 01, o_wr_acc = 1, o_wr_pc = 1 for exactly 1 cycle, 2 cycles after fetch; o_retired = 1.
- RAM_LAT = 3, opcode ADD (4) -> o_rd_ram high for 3 cycles, then WB cycle with o_sel_a = 10, o_sel_b = 0, o_op = 1, o_wr_acc = 1, o_wr_pc = 1; total 5 cycles.
- Stream STO, SUBI, HALT -> o_wr_ram pulse, then o_op = 0 / o_sel_b = 1 pulse, then o_halted = 1, o_busy = 0, o_retired = 2; further valid opcodes ignored.
- OPCODE_W = 5, opcode 9 -> o_illegal = 1, o_halted = 1, no strobes; assert rst_n = 0 -> both clear without a clock edge.
- i_instr_valid low for 4 cycles in FETCH -> no strobes, o_busy = 1; i_run dropped during MEM_WAIT -> WB completes, then IDLE, o_busy = 0.
- CNT_W = 2, run 5 LDI instructions -> o_retired saturates at 3.
